// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with optional 2-entry skid buffer and synchronous flush.
// The head entry drives out_data; there is no combinational path from in_data to out_data.
module pipe_stage_reg #(
  parameter int unsigned DATA_WIDTH = 37,
  parameter bit          SKID       = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q, main_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  ready_q;
  logic                  in_fire, out_fire;

  assign out_valid = (state_q != StEmpty);
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // With the skid buffer, in_ready comes from a flop so it never depends on out_ready.
  assign in_ready = ~reset & (SKID ? ready_q : ((state_q == StEmpty) | out_ready));

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      StEmpty: begin
        if (in_fire) begin
          state_d = StOne;
          main_d  = in_data;
        end
      end
      StOne: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire && SKID) begin
          state_d = StTwo;
          skid_d  = in_data;
        end else if (out_fire) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (out_fire) begin
          state_d = StOne;
          main_d  = skid_q;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Squash: whatever was offered this cycle is dropped; an out_fire still counts as delivered.
    if (flush) begin
      state_d = StEmpty;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= (state_d != StTwo);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector table on the skid variant, hand sequences for reset
// and streaming, and a randomised phase on both variants checked by an in-order scoreboard.
module tb_pipe_stage_reg;

  localparam int unsigned W = 64;

  logic         clk;
  logic         rst  [2];
  logic         fl   [2];
  logic         iv   [2];
  logic         ir   [2];
  logic [W-1:0] id   [2];
  logic         ov   [2];
  logic         ordy [2];
  logic [W-1:0] od   [2];
  logic [1:0]   occ  [2];

  int n_checks = 0;
  int n_fail   = 0;

  // Index 0: skid variant, index 1: single-register variant.
  pipe_stage_reg #(.DATA_WIDTH(W), .SKID(1'b1)) u_skid (
    .clk      (clk),
    .reset    (rst[0]),
    .flush    (fl[0]),
    .in_valid (iv[0]),
    .in_ready (ir[0]),
    .in_data  (id[0]),
    .out_valid(ov[0]),
    .out_ready(ordy[0]),
    .out_data (od[0]),
    .occupancy(occ[0])
  );

  pipe_stage_reg #(.DATA_WIDTH(W), .SKID(1'b0)) u_noskid (
    .clk      (clk),
    .reset    (rst[1]),
    .flush    (fl[1]),
    .in_valid (iv[1]),
    .in_ready (ir[1]),
    .in_data  (id[1]),
    .out_valid(ov[1]),
    .out_ready(ordy[1]),
    .out_data (od[1]),
    .occupancy(occ[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
    end
  endtask

  task automatic drv(input int d, input logic v, input logic [W-1:0] data, input logic r,
                     input logic f);
    iv[d]   = v;
    id[d]   = data;
    ordy[d] = r;
    fl[d]   = f;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: sampled on the falling edge, each fire is what the next rising edge commits.
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  logic         hold_v [2] = '{1'b0, 1'b0};
  logic [W-1:0] held   [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int           sz;
      logic [W-1:0] e;
      sz = (d == 0) ? q0.size() : q1.size();
      if (rst[d]) begin
        if (d == 0) q0.delete();
        else q1.delete();
        hold_v[d] = 1'b0;
      end else begin
        chk("sb_occupancy", W'(occ[d]), W'(sz));
        if (d == 0) chk("sb_in_ready", W'(ir[d]), W'(sz < 2));
        else chk("sb_in_ready", W'(ir[d]), W'((sz == 0) || ordy[d]));
        if (hold_v[d]) begin
          chk("sb_stall_valid", W'(ov[d]), 1);
          chk("sb_stall_data", od[d], held[d]);
        end
        hold_v[d] = ov[d] && !ordy[d] && !fl[d];
        held[d]   = od[d];
        if (ov[d] && ordy[d]) begin
          if (sz == 0) begin
            chk("sb_unexpected_output", od[d], 'x);
          end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk("sb_out_data", od[d], e);
          end
        end
        if (fl[d]) begin
          if (d == 0) q0.delete();
          else q1.delete();
        end else if (iv[d] && ir[d]) begin
          if (d == 0) q0.push_back(id[d]);
          else q1.push_back(id[d]);
        end
      end
    end
  end

  typedef struct {
    logic         iv;
    logic [W-1:0] id;
    logic         ordy;
    logic         fl;
    logic         ov;
    logic [W-1:0] od;
    logic         ir;
    logic [1:0]   occ;
  } vec_t;

  function automatic vec_t mk(logic v, logic [W-1:0] data, logic r, logic f, logic eov,
                              logic [W-1:0] eod, logic eir, logic [1:0] eocc);
    vec_t t;
    t = '{v, data, r, f, eov, eod, eir, eocc};
    return t;
  endfunction

  vec_t vecs[13];

  initial begin
    // Expected outputs are those seen in the same cycle, before the edge commits the inputs.
    vecs[0]  = mk(1, 'h13, 1, 0, 0, 'h00, 1, 0);
    vecs[1]  = mk(0, 'h00, 0, 0, 1, 'h13, 1, 1);
    vecs[2]  = mk(1, 'h11, 1, 0, 1, 'h13, 1, 1);
    vecs[3]  = mk(1, 'h22, 0, 0, 1, 'h11, 1, 1);
    vecs[4]  = mk(1, 'h33, 0, 0, 1, 'h11, 0, 2);
    vecs[5]  = mk(0, 'h00, 1, 0, 1, 'h11, 0, 2);
    vecs[6]  = mk(0, 'h00, 1, 0, 1, 'h22, 1, 1);
    vecs[7]  = mk(1, 'h44, 0, 0, 0, 'h00, 1, 0);
    vecs[8]  = mk(1, 'h55, 0, 0, 1, 'h44, 1, 1);
    vecs[9]  = mk(1, 'h66, 0, 1, 1, 'h44, 0, 2);
    vecs[10] = mk(1, 'h77, 1, 0, 0, 'h00, 1, 0);
    vecs[11] = mk(1, 'h88, 1, 1, 1, 'h77, 1, 1);
    vecs[12] = mk(0, 'h00, 1, 0, 0, 'h00, 1, 0);

    for (int d = 0; d < 2; d++) begin
      drv(d, 0, '0, 0, 0);
      rst[d] = 1'b1;
    end
    repeat (2) next_cycle();
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_out_valid", W'(ov[d]), 0);
      chk("reset_out_data", od[d], 0);
      chk("reset_occupancy", W'(occ[d]), 0);
      chk("reset_in_ready", W'(ir[d]), 1);
    end
    next_cycle();

    for (int i = 0; i < 13; i++) begin
      drv(0, vecs[i].iv, vecs[i].id, vecs[i].ordy, vecs[i].fl);
      @(negedge clk);
      chk($sformatf("vec%0d_out_valid", i), W'(ov[0]), W'(vecs[i].ov));
      chk($sformatf("vec%0d_in_ready", i), W'(ir[0]), W'(vecs[i].ir));
      chk($sformatf("vec%0d_occupancy", i), W'(occ[0]), W'(vecs[i].occ));
      if (vecs[i].ov) chk($sformatf("vec%0d_out_data", i), od[0], vecs[i].od);
      next_cycle();
    end

    // Reset while full and out_ready toggling.
    drv(0, 1, 'hA1, 0, 0);
    next_cycle();
    drv(0, 1, 'hB2, 0, 0);
    next_cycle();
    drv(0, 1, 'hC0, 1, 0);
    rst[0] = 1'b1;
    @(negedge clk);
    chk("rst_in_ready_low", W'(ir[0]), 0);
    next_cycle();
    drv(0, 1, 'hC1, 0, 0);
    @(negedge clk);
    chk("rst_out_valid", W'(ov[0]), 0);
    chk("rst_out_data", od[0], 0);
    chk("rst_occupancy", W'(occ[0]), 0);
    chk("rst_in_ready_held", W'(ir[0]), 0);
    next_cycle();
    rst[0] = 1'b0;
    drv(0, 0, '0, 1, 0);
    @(negedge clk);
    chk("rel_in_ready", W'(ir[0]), 1);
    chk("rel_out_valid", W'(ov[0]), 0);
    next_cycle();
    drv(0, 1, 'hC3, 1, 0);
    next_cycle();
    drv(0, 0, '0, 1, 0);
    @(negedge clk);
    chk("rel_first_valid", W'(ov[0]), 1);
    chk("rel_first_data", od[0], 'hC3);
    next_cycle();

    // Single-register variant: back-to-back streaming, then a stall.
    for (int k = 1; k <= 9; k++) begin
      drv(1, k <= 8, W'(k), 1, 0);
      @(negedge clk);
      if (k > 1) begin
        chk("stream_out_valid", W'(ov[1]), 1);
        chk("stream_out_data", od[1], W'(k - 1));
      end
      if (k <= 8) chk("stream_in_ready", W'(ir[1]), 1);
      next_cycle();
    end
    drv(1, 1, 'h9, 1, 0);
    next_cycle();
    drv(1, 1, 'hA, 0, 0);
    @(negedge clk);
    chk("stall_in_ready", W'(ir[1]), 0);
    chk("stall_out_data", od[1], 'h9);
    next_cycle();
    drv(1, 0, '0, 1, 0);
    next_cycle();

    // Randomised traffic on both variants.
    for (int c = 0; c < 10000; c++) begin
      for (int d = 0; d < 2; d++) begin
        drv(d, $urandom_range(0, 3) != 0, {$urandom(), 32'(c)}, $urandom_range(0, 1) == 1,
            $urandom_range(0, 99) == 0);
        rst[d] = ($urandom_range(0, 499) == 0);
      end
      next_cycle();
    end
    for (int d = 0; d < 2; d++) begin
      drv(d, 0, '0, 1, 0);
      rst[d] = 1'b0;
    end
    repeat (4) next_cycle();
    @(negedge clk);
    chk("drain_skid_empty", W'(q0.size()), 0);
    chk("drain_noskid_empty", W'(q1.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
